// File: rtl/counter_16b_sched.sv
// Round-robin scheduler sharing one 16-bit interval counter among requesters.
// Grants the counter, clears it, enables it for L ticks, then reports done/abort.
module counter_16b_sched #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  req_len,
  input  logic                 hold,
  input  logic [15:0]          ctr_count,
  input  logic                 ctr_tc,
  output logic                 ctr_reset,
  output logic                 ctr_en,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic [N_REQ-1:0]     abort,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]      tgt_q, tgt_d;
  logic             done_flag_q, done_flag_d;

  logic [IDX_W-1:0] pick;
  logic             pick_vld;
  logic [IDX_W-1:0] scan;
  logic [N_REQ-1:0] owner_oh;
  logic             clr;
  logic             run_en;

  function automatic logic [IDX_W-1:0] wrap_inc(
    input logic [IDX_W-1:0] a
  );
    if (a == IDX_W'(N_REQ - 1))
      return '0;
    return a + 1'b1;
  endfunction

  assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan     = rr_ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_vld && req[scan]) begin
        pick     = scan;
        pick_vld = 1'b1;
      end
      scan = wrap_inc(scan);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      tgt_q       <= '0;
      done_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      tgt_q       <= tgt_d;
      done_flag_q <= done_flag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    tgt_d       = tgt_q;
    done_flag_d = done_flag_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d     = CLEAR;
          owner_d     = pick;
          // L=0 wraps to FFFF, i.e. a full 65536-tick interval
          tgt_d       = req_len[{pick, 4'b0000} +: 16] - 16'd1;
          done_flag_d = 1'b0;
        end
      end
      CLEAR: state_d = RUN;
      RUN: begin
        if (!req[owner_q]) begin
          state_d     = FIN;
          done_flag_d = 1'b0;
        end else if (!hold &&
                     (ctr_count == tgt_q || ctr_tc)) begin
          state_d     = FIN;
          done_flag_d = 1'b1;
        end
      end
      FIN: begin
        state_d  = IDLE;
        rr_ptr_d = wrap_inc(owner_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant  = '0;
    done   = '0;
    abort  = '0;
    busy   = 1'b0;
    clr    = 1'b0;
    run_en = 1'b0;
    unique case (state_q)
      IDLE: ;
      CLEAR: begin
        grant = owner_oh;
        busy  = 1'b1;
        clr   = 1'b1;
      end
      RUN: begin
        grant  = owner_oh;
        busy   = 1'b1;
        run_en = ~hold;
      end
      FIN: begin
        grant = owner_oh;
        busy  = 1'b1;
        if (done_flag_q)
          done = owner_oh;
        else
          abort = owner_oh;
      end
      default: ;
    endcase
  end

  assign ctr_reset = reset | clr;
  assign ctr_en    = run_en & ~reset;

endmodule

// File: tb/tb_counter_16b_sched.sv
// Bench for counter_16b_sched with a behavioural shared counter.
// done/abort pulses are scored against a queue of expected events.
module tb_counter_16b_sched;
  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [16*N-1:0] req_len = '0;
  logic           hold = 1'b0;
  logic [15:0]    cnt = '0;
  logic           tc;
  logic           ctr_reset, ctr_en, busy;
  logic [N-1:0]   grant, done, abort;

  int cyc = 0;
  int en_total = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    bit d;
    int who;
    int c;
  } ev_t;
  ev_t sb[$];

  counter_16b_sched #(.N_REQ(N), .IDX_W(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_len   (req_len),
    .hold      (hold),
    .ctr_count (cnt),
    .ctr_tc    (tc),
    .ctr_reset (ctr_reset),
    .ctr_en    (ctr_en),
    .grant     (grant),
    .done      (done),
    .abort     (abort),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ctr_en) en_total <= en_total + 1;
    if (ctr_reset) cnt <= '0;
    else if (ctr_en) cnt <= cnt + 16'd1;
  end
  assign tc = &cnt;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_len(int i, logic [15:0] l);
    req_len[16*i +: 16] = l;
  endtask

  task automatic push(bit d, int who, int c);
    ev_t e;
    e.d = d;
    e.who = who;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic wait_drain(int budget);
    while (sb.size() != 0 && budget > 0) begin
      step(1);
      budget--;
    end
    chk("drain", sb.size(), 0);
  endtask

  always @(negedge clock) begin
    if ((done | abort) != 0) begin
      ev_t e;
      chk("excl", {31'd0, (done != 0) && (abort != 0)}, 0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {24'd0, done, abort}, 0);
      end else begin
        e = sb.pop_front();
        chk("ev_kind", {31'd0, done != 0}, {31'd0, e.d});
        chk("ev_who", {28'd0, done | abort}, 1 << e.who);
        chk("ev_cyc", cyc, e.c);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int base;

    // reset state
    step(3);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", ctr_en, 0);
    chk("rst_ctr_reset", ctr_reset, 1);
    chk("rst_pulse", {done, abort}, 0);
    reset = 1'b0;
    step(1);
    chk("idle_ctr_reset", ctr_reset, 0);

    // single request, L=3
    t = cyc;
    set_len(0, 16'd3);
    req = 4'b0001;
    base = en_total;
    push(1, 0, t + 5);
    step(1);
    chk("t1_clr_grant", grant, 4'b0001);
    chk("t1_clr_reset", ctr_reset, 1);
    chk("t1_clr_en", ctr_en, 0);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("t1_en", ctr_en, 1);
      chk("t1_cnt", cnt, k);
    end
    step(1);
    chk("t1_fin_grant", grant, 4'b0001);
    req = '0;
    step(1);
    chk("t1_busy", busy, 0);
    chk("t1_en_total", en_total - base, 3);

    // round robin, all L=1, from a fresh pointer
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_len(i, 16'd1);
    req = 4'b1111;
    t = cyc;
    for (int k = 0; k < 5; k++) push(1, k % 4, t + 3 + 4 * k);
    step(1);
    chk("rr_grant0", grant, 4'b0001);
    for (int k = 1; k < 5; k++) begin
      step(4);
      chk("rr_grant", grant, 1 << (k % 4));
    end
    step(2);
    req = '0;
    wait_drain(20);
    step(2);

    // L=0 means 65536 enabled ticks
    t = cyc;
    set_len(1, 16'd0);
    req = 4'b0010;
    base = en_total;
    push(1, 1, t + 65538);
    step(65537);
    chk("long_cnt", cnt, 16'hFFFF);
    chk("long_tc", tc, 1);
    chk("long_en", ctr_en, 1);
    step(1);
    chk("long_fin_grant", grant, 4'b0010);
    chk("long_cnt_wrap", cnt, 0);
    req = '0;
    step(1);
    chk("long_en_total", en_total - base, 65536);

    // hold for 4 cycles after second RUN cycle, L=5
    step(1);
    t = cyc;
    set_len(2, 16'd5);
    req = 4'b0100;
    base = en_total;
    push(1, 2, t + 11);
    step(4);
    hold = 1'b1;
    #1;
    chk("hold_en", ctr_en, 0);
    step(1);
    chk("hold_cnt", cnt, 2);
    step(3);
    chk("hold_cnt_end", cnt, 2);
    hold = 1'b0;
    step(3);
    chk("hold_fin_grant", grant, 4'b0100);
    req = '0;
    step(1);
    chk("hold_en_total", en_total - base, 5);

    // abort by owner 3, then pending requester 0 served
    step(1);
    t = cyc;
    set_len(3, 16'd100);
    set_len(0, 16'd2);
    req = 4'b1001;
    push(0, 3, t + 13);
    push(1, 0, t + 18);
    step(1);
    chk("ab_grant3", grant, 4'b1000);
    step(11);
    chk("ab_cnt", cnt, 10);
    req = 4'b0001;
    step(3);
    chk("ab_grant0", grant, 4'b0001);
    step(3);
    req = '0;
    wait_drain(20);

    // reset mid-RUN, pointer restarts at 0
    step(2);
    t = cyc;
    set_len(2, 16'd20);
    req = 4'b0100;
    step(9);
    chk("mr_cnt", cnt, 7);
    reset = 1'b1;
    #1;
    chk("mr_ctr_reset", ctr_reset, 1);
    chk("mr_en", ctr_en, 0);
    step(1);
    chk("mr_grant", grant, 0);
    chk("mr_busy", busy, 0);
    chk("mr_pulse", {done, abort}, 0);
    chk("mr_cnt_clr", cnt, 0);
    reset = 1'b0;
    set_len(0, 16'd1);
    req = 4'b0101;
    push(1, 0, t + 13);
    step(1);
    chk("mr_regrant", grant, 4'b0001);
    step(2);
    req = '0;
    wait_drain(20);
    step(2);
    chk("end_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
